// File: rtl/baverage_win.sv
`default_nettype none
// ============================================================================
//  Module      : baverage_win
//  Description : Sliding-window averager with a hysteretic threshold flag.
//                Qualified W-bit unsigned samples enter a DEPTH-entry ring
//                buffer. A running sum of the window gives a floor average,
//                and a registered flag y is driven from that average with
//                separate set/clear thresholds.
//  Ports       : clk      - rising-edge clock
//                rst      - asynchronous reset, active low
//                x        - sample data (W bits)
//                in_valid - x accepted on this rising edge when high
//                clear    - synchronous window flush (wins over in_valid)
//                avg      - floor(sum / DEPTH)
//                sum      - running sum of the window (W+log2(DEPTH) bits)
//                full     - window holds DEPTH samples
//                y        - hysteretic "average high" flag
//  Revision    : 1.0 - initial release
// ============================================================================
module baverage_win #(
   parameter int W         = 2,
   parameter int DEPTH     = 4,
   parameter int THRESH_HI = 1,
   parameter int THRESH_LO = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [W-1:0]                  x,
   input  logic                          in_valid,
   input  logic                          clear,
   output logic [W-1:0]                  avg,
   output logic [W+$clog2(DEPTH)-1:0]    sum,
   output logic                          full,
   output logic                          y
);

   localparam int LG = $clog2(DEPTH);
   localparam int SW = W + LG;

   localparam logic [W-1:0]  c_thresh_hi = THRESH_HI[W-1:0];
   localparam logic [W-1:0]  c_thresh_lo = THRESH_LO[W-1:0];
   localparam logic [LG:0]   c_depth     = (LG+1)'(DEPTH);
   localparam logic [LG:0]   c_depth_m1  = (LG+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FILLING = 2'd1,
      S_FULL    = 2'd2
   } fill_state_t;

   fill_state_t         r_state;
   fill_state_t         w_state_nxt;

   logic [W-1:0]        r_buf [DEPTH];
   logic [LG-1:0]       r_wr_ptr;
   logic [LG:0]         r_count;
   logic [SW-1:0]       r_sum;
   logic                r_y;

   logic                w_accept;
   logic [SW-1:0]       w_sum_nxt;
   logic [W-1:0]        w_avg_nxt;
   logic                w_y_nxt;

   assign w_accept  = in_valid & ~clear;

   // The oldest entry is subtracted before the new sample overwrites it.
   // While filling it is still zero from the last flush, so the same
   // expression serves both phases. No underflow is possible because every
   // stored entry is already part of r_sum.
   assign w_sum_nxt = r_sum + SW'(x) - SW'(r_buf[r_wr_ptr]);
   assign w_avg_nxt = W'(w_sum_nxt >> LG);

   // Fill state machine: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fill state machine: next state and flag decision
   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = 1'b0;
      if (clear) begin
         w_state_nxt = S_EMPTY;
      end else if (in_valid) begin
         case (r_state)
            S_EMPTY:   w_state_nxt = S_FILLING;
            S_FILLING: w_state_nxt = (r_count == c_depth_m1) ? S_FULL : S_FILLING;
            S_FULL:    w_state_nxt = S_FULL;
            default:   w_state_nxt = S_EMPTY;
         endcase
      end
      // Flag is judged against the post-edge window, so it moves together
      // with full and avg rather than one cycle behind them.
      if (w_state_nxt == S_FULL) begin
         if (r_y) begin
            w_y_nxt = !(w_avg_nxt < c_thresh_lo);
         end else begin
            w_y_nxt = (w_avg_nxt >= c_thresh_hi);
         end
      end
   end

   // Datapath: ring buffer, pointer, fill count, running sum and flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_sum    <= '0;
         r_y      <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_sum    <= '0;
         r_y      <= 1'b0;
      end else if (w_accept) begin
         r_buf[r_wr_ptr] <= x;
         // DEPTH is a power of two, so natural overflow gives the wrap.
         r_wr_ptr        <= r_wr_ptr + 1'b1;
         if (r_count != c_depth) begin
            r_count <= r_count + 1'b1;
         end
         r_sum           <= w_sum_nxt;
         r_y             <= w_y_nxt;
      end
   end

   assign sum  = r_sum;
   assign avg  = W'(r_sum >> LG);
   assign full = (r_state == S_FULL);
   assign y    = r_y;

endmodule
`default_nettype wire

// File: doc/baverage_win.md
Name: baverage_win

Overview:
- Parameterised sliding-window averager, successor to the 2-bit single-output bit averager.
- Accepts qualified W-bit unsigned samples and keeps the last DEPTH samples in a ring buffer. A running sum yields a floor average.
- Drives a thresholded decision flag with hysteresis.
- Sits between sample producers (sensors, counters) and control logic that needs a debounced "average high" indication.

Parameters:
- W, 2, sample width in bits (>=1)
- DEPTH, 4, window length in samples; power of two, >=2
- THRESH_HI, 1, y sets when avg >= THRESH_HI (W bits)
- THRESH_LO, 1, y clears when avg < THRESH_LO; THRESH_LO <= THRESH_HI required

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- x  input  W  sample data
- in_valid  input  1  x accepted on this rising edge when high
- clear  input  1  synchronous window flush
- avg  output  W  floor(sum / DEPTH)
- sum  output  W+log2(DEPTH)  running sum of window contents
- full  output  1  window holds DEPTH samples
- y  output  1  hysteretic threshold flag

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - All buffer entries = 0; wr_ptr = 0; fill count = 0; sum = 0; full = 0; y = 0.
  - avg = 0 because it derives from sum.
- Width rules:
  - SW = W + log2(DEPTH). sum never overflows: max = DEPTH*(2^W-1).
  - avg = sum >> log2(DEPTH), a pure shift with floor semantics and no rounding.
- Accept (in_valid=1, clear=0, rising edge):
  - sum <= sum + x - buf[wr_ptr]; buf[wr_ptr] <= x; wr_ptr <= wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0).
  - Oldest entry is 0 while filling, since the buffer was cleared.
  - Arithmetic is done at SW bits before truncation.
- Latency: sum/avg reflect a sample 1 cycle after its accepting edge (registered sum, combinational shift).
- in_valid=0: all state holds; y holds.
- Fill state machine:
  - EMPTY (count=0) --accept--> FILLING.
  - FILLING --accept with count=DEPTH-1--> FULL. full=1 from the edge that accepts the DEPTH-th sample.
  - FULL stays FULL on accept; count saturates at DEPTH.
  - Any state --clear--> EMPTY.
- y (registered, evaluated on the same edge that updates sum, using the new avg):
  - full=0: y <= 0.
  - full=1 and y=0: y <= (new_avg >= THRESH_HI).
  - full=1 and y=1: y <= !(new_avg < THRESH_LO).
  - y therefore changes in the same cycle as full/avg. No glitch output, no combinational path from x to y.
- clear=1 on an edge: buffer, sum, count, wr_ptr, full and y cleared exactly as reset.
  - clear with in_valid=1 simultaneously: clear wins, sample dropped.
- Reset asserted mid-fill or mid-window: immediate asynchronous clear. First accept after rst release starts a fresh window.
- Window contents are never read back except through sum/avg.

Test Plan:
- Defaults: reset, then x=01 with in_valid on 4 consecutive edges.
  - After edge 3: sum=3, avg=0, full=0, y=0.
  - After edge 4: sum=4, avg=1, full=1, y=1.
- W=2, DEPTH=4, HI=3, LO=2: 4x x=11 gives sum=12, avg=3, y=1. Then x=00 per edge:
  - sum 9/6/3/0, avg 2/1/0/0.
  - y stays 1 at avg=2, clears at avg=1, stays 0.
- Gaps: as in the first scenario but with in_valid=0 for 3 cycles between samples 2 and 3. sum/avg/full/y hold during gaps; final values identical (sum=4, y=1).
- Clear: after 2 samples of 01 (sum=2), assert clear together with in_valid=1, x=11.
  - Next cycle: sum=0, full=0, y=0, sample not counted.
  - 4 further 01 samples give sum=4, y=1.
- Async reset: in FULL state with y=1, drop rst between clock edges. sum, avg, full and y all reach 0 before the next rising edge.
- W=4, DEPTH=8, HI=15, LO=8: 8x x=1111 gives sum=120 (7-bit, no overflow), avg=15, y=1. A 9th sample x=0000 gives sum=105, avg=13, y=1 (wrap-around drops the oldest).
